// File: rtl/gray_pkg.sv
// gray_pkg: mode encoding, per-stage slice bounds and popcount shared by gray_codec_pipe.
package gray_pkg;
    typedef enum logic {GRAY_B2G = 1'b0, GRAY_G2B = 1'b1} gray_mode_e;
    // Stage k (1-based) resolves bits [slice_hi : slice_lo]; slice_hi < 0 means nothing left to resolve.
    function automatic int slice_hi(int width, int stages, int k);
        return width - 1 - (k - 1) * ((width + stages - 1) / stages);
    endfunction
    function automatic int slice_lo(int width, int stages, int k);
        int lo;
        lo = width - k * ((width + stages - 1) / stages);
        return lo < 0 ? 0 : lo;
    endfunction
    function automatic int popcount(logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) n += int'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/gray_codec_pipe_if.sv
// gray_codec_pipe_if: input/output valid-ready bundle for gray_codec_pipe.
// out_step_err exists only when GRAY_CODEC_STEP_CHK_EN is defined.
interface gray_codec_pipe_if #(parameter int WIDTH = 8);
    import gray_pkg::*;
    logic             in_valid;
    logic             in_ready;
    gray_mode_e       in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    gray_mode_e       out_mode;
    logic [WIDTH-1:0] out_data;
`ifdef GRAY_CODEC_STEP_CHK_EN
    logic             out_step_err;
    modport master (output in_valid, in_mode, in_data, out_ready,
                    input in_ready, out_valid, out_mode, out_data, out_step_err);
    modport slave  (input in_valid, in_mode, in_data, out_ready,
                    output in_ready, out_valid, out_mode, out_data, out_step_err);
`else
    modport master (output in_valid, in_mode, in_data, out_ready,
                    input in_ready, out_valid, out_mode, out_data);
    modport slave  (input in_valid, in_mode, in_data, out_ready,
                    output in_ready, out_valid, out_mode, out_data);
`endif
endinterface

// File: rtl/gray_codec_stage.sv
// gray_codec_stage: one pipeline register; resolves Gray->binary bits [HI:LO] of a word
// whose upper bits are already binary. The first stage also does the whole binary->Gray step.
module gray_codec_stage
    import gray_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HI    = 7,
    parameter int LO    = 0,
    parameter bit FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             in_valid,
    input  gray_mode_e       in_mode,
    input  logic [WIDTH-1:0] in_data,
`ifdef GRAY_CODEC_STEP_CHK_EN
    input  logic             in_err,
    output logic             out_err,
`endif
    output logic             out_valid,
    output gray_mode_e       out_mode,
    output logic [WIDTH-1:0] out_data
);
    logic             valid_q, valid_d;
    gray_mode_e       mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH:0]   ext;
    always_comb begin
        ext = {1'b0, in_data};
        for (int i = WIDTH - 1; i >= 0; i--)
            if (i <= HI && i >= LO) ext[i] = ext[i+1] ^ ext[i];
        valid_d = adv ? in_valid : valid_q;
        mode_d  = adv ? in_mode : mode_q;
        data_d  = !adv ? data_q :
                  in_mode == GRAY_G2B ? ext[WIDTH-1:0] :
                  FIRST ? in_data ^ (in_data >> 1) : in_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q  <= GRAY_B2G;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end
`ifdef GRAY_CODEC_STEP_CHK_EN
    logic err_q, err_d;
    always_comb err_d = adv ? in_err : err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign out_err = err_q;
`endif
    assign out_valid = valid_q;
    assign out_mode  = mode_q;
    assign out_data  = data_q;
endmodule

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: pipelined binary<->Gray converter with per-word mode and valid/ready on both sides.
// Define GRAY_CODEC_STEP_CHK_EN to flag Gray inputs that move more than one bit from the previous one.
module gray_codec_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic               clk,
    input logic               rst_n,
    gray_codec_pipe_if.slave  bus
);
    logic             adv;
    logic             v [STAGES+1];
    gray_mode_e       m [STAGES+1];
    logic [WIDTH-1:0] d [STAGES+1];
    // The whole pipe moves in lockstep: bubbles are kept so ordering and latency stay fixed.
    assign adv  = !v[STAGES] || bus.out_ready;
    assign v[0] = bus.in_valid;
    assign m[0] = bus.in_mode;
    assign d[0] = bus.in_data;
`ifdef GRAY_CODEC_STEP_CHK_EN
    logic             e [STAGES+1];
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             seen_q, seen_d, g2b_acc;
    assign g2b_acc = bus.in_valid && adv && bus.in_mode == GRAY_G2B;
    assign e[0]    = g2b_acc && seen_q && popcount(64'(prev_q ^ bus.in_data)) > 1;
    always_comb begin
        prev_d = g2b_acc ? bus.in_data : prev_q;
        seen_d = seen_q || g2b_acc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            seen_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            seen_q <= seen_d;
        end
    end
    assign bus.out_step_err = e[STAGES];
`endif
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        gray_codec_stage #(
            .WIDTH(WIDTH),
            .HI   (slice_hi(WIDTH, STAGES, s + 1)),
            .LO   (slice_lo(WIDTH, STAGES, s + 1)),
            .FIRST(s == 0)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (adv),
            .in_valid (v[s]),
            .in_mode  (m[s]),
            .in_data  (d[s]),
`ifdef GRAY_CODEC_STEP_CHK_EN
            .in_err   (e[s]),
            .out_err  (e[s+1]),
`endif
            .out_valid(v[s+1]),
            .out_mode (m[s+1]),
            .out_data (d[s+1])
        );
    end
    assign bus.in_ready  = adv;
    assign bus.out_valid = v[STAGES];
    assign bus.out_mode  = m[STAGES];
    assign bus.out_data  = d[STAGES];
endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe: randomized scoreboard bench for gray_codec_pipe (8b/2 stages and 4b/4 stages).
// Step-error checks are compiled in when GRAY_CODEC_STEP_CHK_EN is defined.
module tb_gray_codec_pipe;
    import gray_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_codec_pipe_if #(.WIDTH(8)) bus ();
    gray_codec_pipe_if #(.WIDTH(4)) bus4 ();
    gray_codec_pipe #(.WIDTH(8), .STAGES(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    gray_codec_pipe #(.WIDTH(4), .STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {logic m; logic [7:0] d; logic [7:0] orig; logic e;} exp_t;
    exp_t q[$];
    int n_cmp = 0, n_err = 0;
    logic [7:0] prev = '0;
    logic seen = 1'b0;

    function automatic logic [7:0] b2g(logic [7:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [7:0] g2b(logic [7:0] g);
        logic [7:0] b;
        b = '0;
        for (int s = 0; s < 8; s++) b ^= g >> s;
        return b;
    endfunction
    // Reference for the main DUT; tracks the last accepted Gray input for the step check.
    function automatic exp_t model(logic m, logic [7:0] d);
        exp_t r;
        r.m = m;
        r.orig = d;
        r.d = m ? g2b(d) : b2g(d);
        r.e = 1'b0;
        if (m) begin
            r.e = seen && ($countones(d ^ prev) > 1);
            prev = d;
            seen = 1'b1;
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic m, input logic [7:0] d, input logic r);
        @(posedge clk);
        #1;
        bus.in_valid = v; bus.in_mode = gray_mode_e'(m); bus.in_data = d; bus.out_ready = r;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive4(input logic v, input logic m, input logic [3:0] d);
        @(posedge clk);
        #1;
        bus4.in_valid = v; bus4.in_mode = gray_mode_e'(m); bus4.in_data = d; bus4.out_ready = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0; bus.in_mode = GRAY_B2G; bus.in_data = '0; bus.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_mode = GRAY_B2G; bus4.in_data = '0; bus4.out_ready = 1'b0;
        #2;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
        n_cmp++; if (bus.out_mode !== GRAY_B2G) begin n_err++; $display("FAIL reset_out_mode: got %b want 0", bus.out_mode); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus4.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_w4_out_valid: got %b want 0", bus4.out_valid); end
`ifdef GRAY_CODEC_STEP_CHK_EN
        n_cmp++; if (bus.out_step_err !== 1'b0) begin n_err++; $display("FAIL reset_step_err: got %b want 0", bus.out_step_err); end
`endif
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_latency(input logic m, input logic [7:0] din, input logic [7:0] want);
        exp_t x;
        drive(1'b1, m, din, 1'b1);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL lat_in_ready: got %b want 1", bus.in_ready); end
        x = model(m, din);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_early: out_valid %b want 0 one edge after accept", bus.out_valid); end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== want || bus.out_mode !== m || x.d !== want) begin
            n_err++;
            $display("FAIL lat_result m=%b in=%h: got v=%b d=%h m=%b want v=1 d=%h m=%b", m, din, bus.out_valid, bus.out_data, bus.out_mode, want, m);
        end
    endtask

    task automatic test_back_to_back;
        exp_t x;
        q.delete();
        for (int c = 0; c < 258; c++) begin
            drive(c < 256, c[0], 8'(c), 1'b1);
            n_cmp++; if (bus.out_valid !== 1'(c >= 2)) begin n_err++; $display("FAIL b2b_rate c=%0d: out_valid %b want %b", c, bus.out_valid, c >= 2); end
            if (bus.out_valid === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL b2b_extra: unexpected result %h", bus.out_data); end
                else begin
                    x = q.pop_front();
                    if (bus.out_data !== x.d || bus.out_mode !== x.m || (x.m ? b2g(bus.out_data) : g2b(bus.out_data)) !== x.orig) begin
                        n_err++;
                        $display("FAIL b2b_data in=%h: got d=%h m=%b want d=%h m=%b", x.orig, bus.out_data, bus.out_mode, x.d, x.m);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_mode, bus.in_data));
        end
        n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL b2b_lost: %0d results missing want 0", q.size()); end
    endtask

    task automatic test_w4s4;
        exp_t x;
        exp_t q4[$];
        int got = 0;
        for (int c = 0; c < 36; c++) begin
            drive4(c < 32, c >= 16, 4'(c));
            n_cmp++; if (bus4.out_valid !== 1'(c >= 4)) begin n_err++; $display("FAIL w4_rate c=%0d: out_valid %b want %b", c, bus4.out_valid, c >= 4); end
            if (bus4.out_valid === 1'b1 && q4.size() != 0) begin
                x = q4.pop_front();
                got++;
                n_cmp++;
                if (bus4.out_data !== x.d[3:0] || bus4.out_mode !== x.m) begin
                    n_err++;
                    $display("FAIL w4_data in=%h m=%b: got %h want %h", x.orig[3:0], x.m, bus4.out_data, x.d[3:0]);
                end
            end
            if (bus4.in_valid && bus4.in_ready) begin
                x.m = bus4.in_mode; x.orig = {4'h0, bus4.in_data};
                x.d = x.m ? g2b(x.orig) : b2g(x.orig);
                x.e = 1'b0;
                q4.push_back(x);
            end
        end
        n_cmp++; if (got != 32) begin n_err++; $display("FAIL w4_count: got %0d want 32", got); end
    endtask

    task automatic test_backpressure;
        exp_t x;
        int sent = 0, got = 0;
        logic hold = 1'b0;
        logic [7:0] hold_d = '0;
        logic hold_m = 1'b0;
        q.delete();
        for (int c = 0; c < 400 && got < 10; c++) begin
            drive(sent < 10 && $urandom_range(3) != 0, 1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)));
            n_cmp++; if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin n_err++; $display("FAIL bp_in_ready: got %b with out_valid=%b out_ready=%b", bus.in_ready, bus.out_valid, bus.out_ready); end
            if (hold) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== hold_d || bus.out_mode !== hold_m) begin
                    n_err++;
                    $display("FAIL bp_freeze: got v=%b d=%h m=%b want v=1 d=%h m=%b", bus.out_valid, bus.out_data, bus.out_mode, hold_d, hold_m);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL bp_extra: unexpected result %h", bus.out_data); end
                else begin
                    x = q.pop_front();
                    got++;
                    if (bus.out_data !== x.d || bus.out_mode !== x.m) begin n_err++; $display("FAIL bp_data #%0d: got d=%h m=%b want d=%h m=%b", got, bus.out_data, bus.out_mode, x.d, x.m); end
`ifdef GRAY_CODEC_STEP_CHK_EN
                    n_cmp++; if (bus.out_step_err !== x.e) begin n_err++; $display("FAIL bp_step_err #%0d: got %b want %b", got, bus.out_step_err, x.e); end
`endif
                end
            end
            if (bus.in_valid && bus.in_ready) begin q.push_back(model(bus.in_mode, bus.in_data)); sent++; end
            hold = bus.out_valid && !bus.out_ready;
            hold_d = bus.out_data;
            hold_m = bus.out_mode;
        end
        n_cmp++; if (got != 10 || q.size() != 0) begin n_err++; $display("FAIL bp_count: got %0d left %0d want 10 and 0", got, q.size()); end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_dup: out_valid %b want 0 after drain", bus.out_valid); end
        end
    endtask

    task automatic test_reset_midflight;
        drive(1'b1, 1'b0, 8'h11, 1'b0);
        drive(1'b1, 1'b1, 8'h22, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_stall: got v=%b in_ready=%b want 1 0", bus.out_valid, bus.in_ready); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin n_err++; $display("FAIL rst_async: got v=%b d=%h want 0 00", bus.out_valid, bus.out_data); end
        #1 rst_n = 1'b1;
        q.delete();
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_ghost c=%0d: out_valid %b want 0", c, bus.out_valid); end
        end
        test_latency(1'b1, 8'h80, 8'hFF);
    endtask

`ifdef GRAY_CODEC_STEP_CHK_EN
    task automatic test_step;
        logic [7:0] ins [4];
        logic want [4];
        int got = 0;
        ins = '{8'h01, 8'h03, 8'h03, 8'h00};
        want = '{1'b0, 1'b0, 1'b0, 1'b1};
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 7; c++) begin
            drive(c < 4, 1'b1, c < 4 ? ins[c] : 8'h00, 1'b1);
            if (bus.out_valid === 1'b1 && got < 4) begin
                n_cmp++;
                if (bus.out_step_err !== want[got] || bus.out_data !== g2b(ins[got])) begin
                    n_err++;
                    $display("FAIL step_err #%0d in=%h: got err=%b d=%h want err=%b d=%h", got, ins[got], bus.out_step_err, bus.out_data, want[got], g2b(ins[got]));
                end
                got++;
            end
        end
        n_cmp++; if (got != 4) begin n_err++; $display("FAIL step_count: got %0d want 4", got); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency(1'b0, 8'h2D, 8'h3B);
        test_latency(1'b1, 8'h3B, 8'h2D);
        test_back_to_back();
        test_w4s4();
        test_backpressure();
        test_reset_midflight();
`ifdef GRAY_CODEC_STEP_CHK_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gray_codec_pipe.md
# gray_codec_pipe

Parametrised, pipelined binary/Gray code converter with per-transaction mode select and valid/ready handshakes on both sides. It generalises the team's fixed 4-bit binary-to-Gray converter to any width and adds the reverse Gray-to-binary direction. The serial XOR chain of the Gray-to-binary direction is split across a configurable number of register stages. The block sits between counter/sensor domains and consumers that need either encoding, such as FIFO pointer crossings and encoder readback.

## Interface
- WIDTH, 8, data width in bits; 2..64
- STAGES, 2, pipeline register stages (= latency); 1..WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block accepts the input word this cycle
- in_mode  in  1  0 = binary→Gray, 1 = Gray→binary
- in_data  in  WIDTH  word to convert
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_mode  out  1  mode of the word carried with the result
- out_data  out  WIDTH  converted word
- out_step_err  out  1  present only with GRAY_CODEC_STEP_CHK_EN (see Configuration)

## Operation
- Binary→Gray: g = b ^ (b >> 1). The full result is formed in stage 1 and carried unchanged through the later stages.
- Gray→binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. This is resolved MSB-first. Stage k (1-based) resolves bits [WIDTH-1-(k-1)·C : max(0, WIDTH-k·C)], where C = ceil(WIDTH/STAGES). Each stage carries the remaining Gray bits and the partial binary word. A stage that has no bits left to resolve passes its data through.
- Every stage holds a valid bit, the mode, and the data.
- Global advance: adv = !out_valid || out_ready. When adv is 1, all stages shift by one. When adv is 0, all stages hold.
- in_ready = adv. A transfer occurs when in_valid && in_ready. A cycle without a transfer loads a bubble (valid = 0) into stage 1.
- Bubbles are not compressed. Throughput is one word per cycle while out_ready is held high.
- Results leave in acceptance order. Mixed modes may be interleaved back-to-back.

## Timing
- Reset: all stage valid bits = 0 and all data/mode registers = 0. Output reset values are out_valid = 0, out_data = 0, out_mode = 0, out_step_err = 0, and in_ready = 1.
- Latency: a word accepted at edge N appears with out_valid = 1 after edge N+STAGES−1, i.e. it is registered STAGES times, counting the acceptance edge.
- out_valid && !out_ready freezes out_data, out_mode, out_step_err, and all stages. in_ready stays 0 until the result is taken.
- Simultaneous output accept and input accept in the same cycle is allowed. This is how full throughput is reached.
- Reset asserted mid-operation discards all in-flight words immediately, without waiting for a clock edge. No partial result is emitted after reset releases.
- in_valid is not required to be held once asserted. Words not accepted are not converted.

## Configuration
- Macro GRAY_CODEC_STEP_CHK_EN.
- Defined:
  - Adds port out_step_err and a WIDTH-bit register holding the last accepted Gray→binary input word, plus a seen flag, both cleared by reset.
  - For each accepted mode-1 word with seen = 1, out_step_err travels with the word and is 1 when the Hamming distance from the previous mode-1 input is greater than 1.
  - A distance of 0 (repeated sample) is not an error. Mode-0 words never flag and do not update the register.
  - The first mode-1 word after reset never flags.
- Undefined: the port, register, and comparison logic do not exist. The datapath is otherwise identical.

## Structure
- Package gray_pkg:
  - typedef gray_mode_e (GRAY_B2G = 0, GRAY_G2B = 1)
  - function for the per-stage bit-slice bounds
  - popcount helper for the step check
- One sub-module, gray_codec_stage:
  - one register stage with hold/advance, valid, mode, and partial-resolve logic for its slice
  - instantiated STAGES times in a generate loop

## Test plan
- WIDTH=8, STAGES=2, out_ready=1: mode 0, in_data 0x2D → out_data 0x3B, out_mode 0, exactly 2 cycles after acceptance.
- Same configuration: mode 1, in_data 0x3B → 0x2D. Then back-to-back alternating modes over 0x00..0xFF → each round-trip matches and one result is produced per cycle.
- WIDTH=4, STAGES=4: all 16 values in both modes. Results match the g = b^(b>>1) reference model, including 0xF → 0x8 for b2g and 0x8 → 0xF for g2b.
- Back-pressure: stream 10 words while out_ready toggles pseudo-randomly. Expect no loss, duplication, or reordering. in_ready = 0 in every cycle where out_valid && !out_ready.
- Reset mid-flight: accept 2 words, then pulse rst_n low between edges. out_valid drops to 0 immediately and nothing is emitted after release; the next word then converts correctly.
- With GRAY_CODEC_STEP_CHK_EN: mode-1 inputs 0x01, 0x03, 0x03, 0x00 → out_step_err = 0, 0, 0, 1. The first word after reset is 0.
